// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 core S-box sharing logic.
//   sbox_own_t : which requester owns the shared SubWord result
//   ARB_RR     : round-robin arbitration between KX and DP
//   ARB_PRIO   : KX fixed priority, DP forced after MAX_WAIT KX grants
package aes_pkg;

  typedef enum logic {
    OWN_DP = 1'b0,
    OWN_KX = 1'b1
  } sbox_own_t;

  localparam int ARB_RR   = 0;
  localparam int ARB_PRIO = 1;

endpackage : aes_pkg

// File: rtl/aes_sbox.sv
// AES forward S-box, one byte, purely combinational.
//   in_byte  : byte to substitute
//   out_byte : S(in_byte)
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // NOTE: the table is a constant ROM, not state, so it has no reset and
  // no clock; it folds into plain logic.
  localparam logic [0:255][7:0] SBOX_TABLE = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_byte = SBOX_TABLE[in_byte];

endmodule : aes_sbox

// File: rtl/aes_subword.sv
// 32-bit SubWord: four independent byte S-boxes, combinational.
//   word_i : word to substitute
//   word_o : byte i of word_o = S(byte i of word_i)
module aes_subword (
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  for (genvar i = 0; i < 4; i++) begin : g_byte
    aes_sbox u_sbox (
      .in_byte  (word_i[8*i +: 8]),
      .out_byte (word_o[8*i +: 8])
    );
  end

endmodule : aes_subword

// File: rtl/aes_sbox_arb.sv
// Arbiter sharing one SubWord lane between the key-expansion engine (KX)
// and the round datapath (DP), followed by a single registered output slot.
//   mclk, rst_n      : clock, asynchronous active-low reset
//   flush            : synchronous abort of the output slot and arbitration
//   kx_req_* / dp_*  : valid/ready request channels (32-bit words)
//   kx_rsp_* / dp_*  : valid/ready response channels (substituted words)
//   busy             : output slot holds a result
module aes_sbox_arb
  import aes_pkg::*;
#(
  parameter int ARB_MODE = ARB_RR,
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 4
) (
  input  logic        mclk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        kx_req_valid,
  output logic        kx_req_ready,
  input  logic [31:0] kx_req_data,
  output logic        kx_rsp_valid,
  input  logic        kx_rsp_ready,
  output logic [31:0] kx_rsp_data,
  input  logic        dp_req_valid,
  output logic        dp_req_ready,
  input  logic [31:0] dp_req_data,
  output logic        dp_rsp_valid,
  input  logic        dp_rsp_ready,
  output logic [31:0] dp_rsp_data,
  output logic        busy
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  logic              out_vld_q,  out_vld_d;
  sbox_own_t         out_own_q,  out_own_d;
  logic [31:0]       out_data_q, out_data_d;
  sbox_own_t         last_gnt_q, last_gnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic        slot_free;
  logic        arb_en;
  logic        gnt_kx;
  logic        gnt_dp;
  logic [31:0] sub_in;
  logic [31:0] sub_out;

  aes_subword u_subword (
    .word_i (sub_in),
    .word_o (sub_out)
  );

  // Arbitration and next-state logic.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    gnt_kx     = 1'b0;
    gnt_dp     = 1'b0;
    out_vld_d  = out_vld_q;
    out_own_d  = out_own_q;
    out_data_d = out_data_q;
    last_gnt_d = last_gnt_q;
    wait_cnt_d = wait_cnt_q;

    // The slot can take a new word when empty or when its owner drains it
    // in this same cycle.
    slot_free = !out_vld_q |
                ((out_own_q == OWN_KX) ? kx_rsp_ready : dp_rsp_ready);
    // rst_n gating keeps ready low for the whole reset assertion.
    arb_en    = slot_free & !flush & rst_n;

    if (arb_en) begin
      if (kx_req_valid && dp_req_valid) begin
        if (ARB_MODE == ARB_PRIO) begin
          gnt_dp = (wait_cnt_q == MAX_WAIT_C);
          gnt_kx = !gnt_dp;
        end else begin
          gnt_dp = (last_gnt_q == OWN_KX);
          gnt_kx = !gnt_dp;
        end
      end else begin
        gnt_kx = kx_req_valid;
        gnt_dp = dp_req_valid;
      end
    end

    sub_in = gnt_kx ? kx_req_data : dp_req_data;

    if (flush) begin
      out_vld_d  = 1'b0;
      last_gnt_d = OWN_DP;
      wait_cnt_d = '0;
    end else if (slot_free) begin
      if (gnt_kx || gnt_dp) begin
        out_vld_d  = 1'b1;
        out_own_d  = gnt_kx ? OWN_KX : OWN_DP;
        out_data_d = sub_out;
        last_gnt_d = gnt_kx ? OWN_KX : OWN_DP;
      end else begin
        out_vld_d  = 1'b0;
      end
    end

    // Aging only counts KX grants that actually made DP wait.
    if (ARB_MODE == ARB_PRIO && !flush) begin
      if (!dp_req_valid || gnt_dp) begin
        wait_cnt_d = '0;
      end else if (gnt_kx && wait_cnt_q != MAX_WAIT_C) begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_own_q  <= OWN_DP;
      out_data_q <= '0;
      last_gnt_q <= OWN_DP;
      wait_cnt_q <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_own_q  <= out_own_d;
      out_data_q <= out_data_d;
      last_gnt_q <= last_gnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign kx_req_ready = gnt_kx;
  assign dp_req_ready = gnt_dp;

  assign kx_rsp_valid = out_vld_q & (out_own_q == OWN_KX);
  assign dp_rsp_valid = out_vld_q & (out_own_q == OWN_DP);
  assign kx_rsp_data  = kx_rsp_valid ? out_data_q : '0;
  assign dp_rsp_data  = dp_rsp_valid ? out_data_q : '0;
  assign busy         = out_vld_q;

endmodule : aes_sbox_arb

// File: tb/tb_aes_sbox_arb.sv
// Bench for aes_sbox_arb: a round-robin instance and a KX-priority instance
// (MAX_WAIT=2) share one stimulus stream. A reference model built from the
// arbitration rules and an S-box derived from GF(2^8) inversion is checked
// against both on every falling edge; directed literals pin the model.
`timescale 1ns/1ps
module tb_aes_sbox_arb;
  import aes_pkg::*;

  logic        mclk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        kv, dv, kr, dr;
  logic [31:0] kd, dd;

  logic        rdy_k [2];
  logic        rdy_d [2];
  logic        rv_k  [2];
  logic        rv_d  [2];
  logic [31:0] rd_k  [2];
  logic [31:0] rd_d  [2];
  logic        bsy   [2];

  int n_vec = 0;
  int n_bad = 0;

  always #5 mclk = ~mclk;

  aes_sbox_arb #(.ARB_MODE(ARB_RR), .MAX_WAIT(4), .WAIT_W(4)) u_rr (
    .mclk(mclk), .rst_n(rst_n), .flush(flush),
    .kx_req_valid(kv), .kx_req_ready(rdy_k[0]), .kx_req_data(kd),
    .kx_rsp_valid(rv_k[0]), .kx_rsp_ready(kr), .kx_rsp_data(rd_k[0]),
    .dp_req_valid(dv), .dp_req_ready(rdy_d[0]), .dp_req_data(dd),
    .dp_rsp_valid(rv_d[0]), .dp_rsp_ready(dr), .dp_rsp_data(rd_d[0]),
    .busy(bsy[0])
  );

  aes_sbox_arb #(.ARB_MODE(ARB_PRIO), .MAX_WAIT(2), .WAIT_W(4)) u_prio (
    .mclk(mclk), .rst_n(rst_n), .flush(flush),
    .kx_req_valid(kv), .kx_req_ready(rdy_k[1]), .kx_req_data(kd),
    .kx_rsp_valid(rv_k[1]), .kx_rsp_ready(kr), .kx_rsp_data(rd_k[1]),
    .dp_req_valid(dv), .dp_req_ready(rdy_d[1]), .dp_req_data(dd),
    .dp_rsp_valid(rv_d[1]), .dp_rsp_ready(dr), .dp_rsp_data(rd_d[1]),
    .busy(bsy[1])
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference S-box from field arithmetic ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
    end
  end

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // ---------------- behavioural model, one per instance ----------------
  bit          m_vld [2];
  bit          m_kx  [2];   // 1: held word belongs to KX
  logic [31:0] m_data[2];
  bit          m_lkx [2];   // 1: last grant went to KX
  int          m_wait[2];
  int          m_mode[2] = '{0, 1};
  int          m_maxw[2] = '{4, 2};

  always @(negedge mclk) begin
    for (int m = 0; m < 2; m++) begin
      bit free, gk, gd;
      string tag;
      tag = (m == 0) ? "rr" : "prio";
      if (!rst_n) begin
        m_vld[m] = 0; m_kx[m] = 0; m_data[m] = '0; m_lkx[m] = 0; m_wait[m] = 0;
      end
      free = !m_vld[m] || (m_kx[m] ? kr : dr);
      gk = 0; gd = 0;
      if (rst_n && free && !flush) begin
        if (kv && dv) begin
          if (m_mode[m] == 1) gd = (m_wait[m] == m_maxw[m]);
          else                gd = m_lkx[m];
          gk = !gd;
        end else begin
          gk = kv; gd = dv;
        end
      end
      check({tag, ".kx_req_ready"}, 32'(rdy_k[m]), 32'(gk));
      check({tag, ".dp_req_ready"}, 32'(rdy_d[m]), 32'(gd));
      check({tag, ".kx_rsp_valid"}, 32'(rv_k[m]), 32'(m_vld[m] && m_kx[m]));
      check({tag, ".dp_rsp_valid"}, 32'(rv_d[m]), 32'(m_vld[m] && !m_kx[m]));
      check({tag, ".kx_rsp_data"}, rd_k[m], (m_vld[m] && m_kx[m]) ? m_data[m] : 32'h0);
      check({tag, ".dp_rsp_data"}, rd_d[m], (m_vld[m] && !m_kx[m]) ? m_data[m] : 32'h0);
      check({tag, ".busy"}, 32'(bsy[m]), 32'(m_vld[m]));
      if (rst_n) begin
        if (flush) begin
          m_vld[m] = 0; m_wait[m] = 0; m_lkx[m] = 0;
        end else if (free) begin
          if (gk || gd) begin
            m_vld[m] = 1; m_kx[m] = gk; m_lkx[m] = gk;
            m_data[m] = subword(gk ? kd : dd);
          end else begin
            m_vld[m] = 0;
          end
        end
        if (m_mode[m] == 1 && !flush) begin
          if (!dv || gd)                      m_wait[m] = 0;
          else if (gk && m_wait[m] < m_maxw[m]) m_wait[m]++;
        end
      end
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic next();
    @(posedge mclk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    kv = 1'b0; kd = '0; dv = 1'b0; dd = '0; kr = 1'b1; dr = 1'b1;
    repeat (2) next();
    kv = 1'b1; kd = 32'h0001_0203; #1;
    check("reset_kx_req_ready", 32'(rdy_k[0]), 32'h0);
    check("reset_busy", 32'(bsy[0]), 32'h0);
    check("reset_kx_rsp_data", rd_k[0], 32'h0);
    kv = 1'b0; rst_n = 1'b1;
    next();

    // Single KX request.
    kv = 1'b1; kd = 32'h0001_0203; #1;
    check("kx_only_ready", 32'(rdy_k[0]), 32'h1);
    next();
    kv = 1'b0;
    check("kx_only_rsp_valid", 32'(rv_k[0]), 32'h1);
    check("kx_only_rsp_data", rd_k[0], 32'h637c_777b);
    check("kx_only_dp_valid", 32'(rv_d[0]), 32'h0);
    next();

    // Return last grant to DP, then round-robin contention.
    flush = 1'b1; next(); flush = 1'b0;
    kv = 1'b1; kd = 32'hffff_ffff; dv = 1'b1; dd = 32'h5252_5252;
    for (int i = 0; i < 6; i++) begin
      bit ek;
      ek = (i % 2 == 0);
      #1;
      check("rr_gnt_kx", 32'(rdy_k[0]), 32'(ek));
      check("rr_gnt_dp", 32'(rdy_d[0]), 32'(!ek));
      next();
      check("rr_rsp_kx_valid", 32'(rv_k[0]), 32'(ek));
      check("rr_rsp_kx_data", rd_k[0], ek ? 32'h1616_1616 : 32'h0);
      check("rr_rsp_dp_valid", 32'(rv_d[0]), 32'(!ek));
    end

    // Backpressure on KX while both keep requesting.
    #1;
    check("bp_kx_gnt", 32'(rdy_k[0]), 32'h1);
    next();
    kr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_kx_ready_low", 32'(rdy_k[0]), 32'h0);
      check("bp_dp_ready_low", 32'(rdy_d[0]), 32'h0);
      check("bp_busy", 32'(bsy[0]), 32'h1);
      check("bp_kx_data_held", rd_k[0], 32'h1616_1616);
      next();
    end
    kr = 1'b1; #1;
    check("bp_release_dp_gnt", 32'(rdy_d[0]), 32'h1);
    check("bp_release_kx_gnt", 32'(rdy_k[0]), 32'h0);
    next();
    check("bp_release_dp_rsp", 32'(rv_d[0]), 32'h1);
    check("bp_release_kx_rsp", 32'(rv_k[0]), 32'h0);

    // KX priority with aging (MAX_WAIT=2): KX,KX,DP,KX,KX,DP.
    flush = 1'b1; next(); flush = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bit ed;
      ed = (i % 3 == 2);
      #1;
      check("prio_gnt_kx", 32'(rdy_k[1]), 32'(!ed));
      check("prio_gnt_dp", 32'(rdy_d[1]), 32'(ed));
      next();
    end

    // Flush while DP result is stalled.
    kv = 1'b0; dv = 1'b1; dd = 32'h5252_5252; #1;
    check("fl_dp_gnt", 32'(rdy_d[0]), 32'h1);
    next();
    check("fl_dp_rsp_valid", 32'(rv_d[0]), 32'h1);
    dr = 1'b0; flush = 1'b1; #1;
    check("fl_no_ready", 32'(rdy_d[0]), 32'h0);
    next();
    flush = 1'b0; dr = 1'b1;
    check("fl_dp_rsp_dropped", 32'(rv_d[0]), 32'h0);
    check("fl_busy_clear", 32'(bsy[0]), 32'h0);
    kv = 1'b1; kd = 32'hffff_ffff; #1;
    check("fl_next_gnt_kx", 32'(rdy_k[0]), 32'h1);
    check("fl_next_gnt_dp", 32'(rdy_d[0]), 32'h0);
    next();
    kv = 1'b0; dv = 1'b0;
    next();

    // Asynchronous reset while a KX result is held.
    kv = 1'b1; kd = 32'h0001_0203; kr = 1'b0; #1;
    check("ar_kx_gnt", 32'(rdy_k[0]), 32'h1);
    next();
    kv = 1'b0;
    check("ar_rsp_before", 32'(rv_k[0]), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("ar_rsp_valid_drop", 32'(rv_k[0]), 32'h0);
    check("ar_busy_drop", 32'(bsy[0]), 32'h0);
    check("ar_rsp_data_drop", rd_k[0], 32'h0);
    next();
    next();
    rst_n = 1'b1; kr = 1'b1;
    kv = 1'b1; kd = 32'h5353_5353; #1;
    check("ar_after_gnt", 32'(rdy_k[0]), 32'h1);
    next();
    kv = 1'b0;
    check("ar_after_rsp_valid", 32'(rv_k[0]), 32'h1);
    check("ar_after_rsp_data", rd_k[0], 32'hedede_ded);
    next();
    next();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_aes_sbox_arb
